// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared constants and helpers for the FP32 adder arbiter
package fp_arb_pkg;

  localparam int FP_W        = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = 2;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  // Leading-zero count of the 27-bit working mantissa {hidden, frac, G, R, S}.
  function automatic logic [4:0] count_lz27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_add_fp.sv
// rtl/fp_add_arbiter_add_fp.sv - combinational IEEE-754 single adder, round-to-nearest-even
module Add_FP
  import fp_arb_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] sum_o
);

  logic        a_nan, b_nan, a_inf, b_inf, a_big, eff_sub, sticky, rnd_up;
  logic [31:0] x, y;
  logic [7:0]  ex, ey, d;
  logic [26:0] mx, my, my_al, m;
  logic [27:0] raw;
  logic [8:0]  e, shift;
  logic [4:0]  lz;
  logic [24:0] mant;

  always_comb begin
    a_nan = (&a_i[30:23]) & (|a_i[22:0]);
    b_nan = (&b_i[30:23]) & (|b_i[22:0]);
    a_inf = (&a_i[30:23]) & ~(|a_i[22:0]);
    b_inf = (&b_i[30:23]) & ~(|b_i[22:0]);

    // x is the operand of larger magnitude; it also supplies the result sign.
    a_big = a_i[30:0] >= b_i[30:0];
    x     = a_big ? a_i : b_i;
    y     = a_big ? b_i : a_i;
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx    = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my    = {y[30:23] != 8'd0, y[22:0], 3'b000};
    d     = ex - ey;

    sticky = 1'b0;
    my_al  = '0;
    if (d >= 8'd27) begin
      my_al = {26'd0, |my};
    end else begin
      sticky = |(my & ~({27{1'b1}} << d));
      my_al  = my >> d;
      my_al[0] = my_al[0] | sticky;
    end

    eff_sub = x[31] ^ y[31];
    raw     = eff_sub ? ({1'b0, mx} - {1'b0, my_al}) : ({1'b0, mx} + {1'b0, my_al});

    e = {1'b0, ex};
    if (raw[27]) begin
      m = {raw[27:2], raw[1] | raw[0]};
      e = e + 9'd1;
    end else begin
      m = raw[26:0];
    end

    // Normalise left, but never below the denormal exponent.
    lz    = count_lz27(m);
    shift = ({4'd0, lz} < (e - 9'd1)) ? {4'd0, lz} : (e - 9'd1);
    if (m != 27'd0) begin
      m = m << shift;
      e = e - shift;
    end

    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    mant   = {1'b0, m[26:3]} + {24'd0, rnd_up};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 9'd1;
    end

    if (m == 27'd0) begin
      sum_o = eff_sub ? 32'd0 : {x[31], 31'd0};
    end else if (mant[23] && e >= 9'd255) begin
      sum_o = {x[31], 8'hFF, 23'd0};
    end else begin
      sum_o = {x[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
      sum_o = FP_QNAN;
    end else if (a_inf) begin
      sum_o = a_i;
    end else if (b_inf) begin
      sum_o = b_i;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one FP32 adder across requesters
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_sum,
  output logic [31:0]             op_count
);

  localparam logic [ID_W-1:0] ID_ONE = 1;

  logic            s1_valid_q, s1_valid_d;
  logic [FP_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [FP_W-1:0] s2_sum_q, s2_sum_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [31:0]     op_count_q, op_count_d;
  logic            rst_dly_q;

  logic            s1_adv, accept_en, ready_en, gnt_found, xfer, rsp_hs;
  logic [ID_W-1:0] gnt_id, scan_idx;
  logic [FP_W-1:0] add_sum;

  Add_FP u_add_fp (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .sum_o (add_sum)
  );

  assign rsp_valid = s2_valid_q & ~rst;
  assign rsp_id    = rst ? '0 : s2_id_q;
  assign rsp_sum   = rst ? '0 : s2_sum_q;
  assign op_count  = op_count_q;

  assign s1_adv    = s1_valid_q & (~s2_valid_q | rsp_ready);
  assign accept_en = ~s1_valid_q | s1_adv;
  // Requesters are held off for the cycle after reset as well.
  assign ready_en  = accept_en & ~rst & ~rst_dly_q;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign xfer      = ready_en & gnt_found;

  // Descending scan so the candidate closest to the pointer wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = ptr_q + k[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;
    op_count_d = op_count_q;

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = add_sum;
      s2_id_d    = s1_id_q;
    end else if (rsp_hs) begin
      s2_valid_d = 1'b0;
    end

    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[gnt_id*FP_W +: FP_W];
      s1_b_d     = req_b[gnt_id*FP_W +: FP_W];
      s1_id_d    = gnt_id;
      ptr_d      = gnt_id + ID_ONE;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (rsp_hs) op_count_d = op_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
      op_count_q <= '0;
      rst_dly_q  <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
      op_count_q <= op_count_d;
      rst_dly_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_sum;
  logic [31:0]    op_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Default lanes: a = 1.0, b = lane index as float, so sums are 1.0, 2.0, 3.0, 4.0.
  logic [31:0] def_b    [N] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
  logic [31:0] lane_sum [N] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

  fp_add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load_default();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'h3F80_0000;
      req_b[i*32 +: 32] = def_b[i];
    end
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    step(); step();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_sum !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_sum: got %h want 0", rsp_sum); end
    n_cmp++; if (op_count !== 32'd0) begin n_bad++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL post_rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_rsp_valid: got %b want 0", rsp_valid); end
    req_valid = '0;
    step();
  endtask

  task automatic test_single();
    do_reset(); load_default();
    req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1: got %b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat2: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_sum !== 32'h4040_0000) begin n_bad++; $display("FAIL single_sum: got %h want 40400000", rsp_sum); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_done: got %b want 0", rsp_valid); end
    n_cmp++; if (op_count !== 32'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", op_count); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset(); load_default();
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'hF : 4'h0;
      #1;
      if (k < 5) begin
        want = 4'b0001 << (k % 4);
        n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want); end
      end
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want 1", k, rsp_valid); end
        n_cmp++; if (rsp_id !== 2'((k - 2) % 4)) begin n_bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, (k - 2) % 4); end
        n_cmp++; if (rsp_sum !== lane_sum[(k - 2) % 4]) begin n_bad++; $display("FAIL rr_sum[%0d]: got %h want %h", k, rsp_sum, lane_sum[(k - 2) % 4]); end
      end
      step();
    end
    n_cmp++; if (op_count !== 32'd5) begin n_bad++; $display("FAIL rr_count: got %0d want 5", op_count); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] want;
    do_reset(); load_default();
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'hF : ((k == 5) ? 4'b0100 : 4'b0000);
      #1;
      want = (k == 0) ? 4'b0001 : ((k == 1) ? 4'b0010 : 4'b0000);
      n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want %b", k, req_ready, want); end
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== lane_sum[0]) begin
          n_bad++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", k, rsp_valid, rsp_id, rsp_sum, lane_sum[0]);
        end
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL bp_rel0: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== lane_sum[1]) begin
      n_bad++; $display("FAIL bp_rel1: got v=%b id=%0d sum=%h want v=1 id=1 sum=%h", rsp_valid, rsp_id, rsp_sum, lane_sum[1]);
    end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dropped: got %b want 0", rsp_valid); end
    n_cmp++; if (op_count !== 32'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", op_count); end
  endtask

  task automatic test_pointer_skip();
    do_reset(); load_default();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL skip_g2: got %b want 0100", req_ready); end
    step();
    req_valid = 4'b1011;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL skip_g3: got %b want 1000", req_ready); end
    step();
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL skip_g0: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step(); step(); step();
  endtask

  task automatic test_special();
    logic [31:0] sa [N] = '{32'h7F80_0000, 32'h4049_0FDB, 32'h3F80_0000, 32'h3F80_0001};
    logic [31:0] sb [N] = '{32'hFF80_0000, 32'hC049_0FDB, 32'h3380_0000, 32'h3380_0000};
    logic [31:0] sx [N] = '{32'h7FC0_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0002};
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = sa[i];
      req_b[i*32 +: 32] = sb[i];
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 4'hF : 4'h0;
      #1;
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k - 2) || rsp_sum !== sx[k - 2]) begin
          n_bad++; $display("FAIL special[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", k - 2, rsp_valid, rsp_id, rsp_sum, k - 2, sx[k - 2]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); load_default();
    rsp_ready = 1'b1; req_valid = 4'hF;
    step(); step(); step();
    n_cmp++; if (op_count !== 32'd1) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 1", op_count); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_bad++; $display("FAIL mid_pre_rsp: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
    rst = 1'b1; rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (op_count !== 32'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", op_count); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_post_ready: got %b want 0000", req_ready); end
    step();
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    req_valid = '0; rsp_ready = 1'b1;
    step(); step(); step();
  endtask

  initial begin
    load_default();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_special();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
